serial_subtractor_ctrl: RTL and testbench

// - Bit-serial W-bit subtractor: computes diff = a - b - bin by time-sharing a single

---
 rtl/serial_subtractor_ctrl_pkg.sv | 13 +
 rtl/serial_subtractor_ctrl_fs.sv | 14 +
 rtl/serial_subtractor_ctrl.sv | 128 ++++++++++++
 tb/tb_serial_subtractor_ctrl.sv | 204 ++++++++++++++++++++
 4 files changed

// File: rtl/serial_subtractor_ctrl_pkg.sv
// Shared definitions for the bit-serial subtractor: FSM state encoding and overflow rule.
package serial_subtractor_ctrl_pkg;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  // Signed overflow of a - b: operand signs differ and the result sign differs from a.
  function automatic logic sub_ovf(input logic a_msb, input logic b_msb, input logic d_msb);
    return (a_msb != b_msb) && (d_msb != a_msb);
  endfunction

endpackage

// File: rtl/serial_subtractor_ctrl_fs.sv
// One-bit full subtractor: diff = a ^ b ^ c; borrow when b + c exceeds a.
// Combinational, no state, no flow control.
module full_subtractor (
  input  logic a,
  input  logic b,
  input  logic c,
  output logic diff,
  output logic borrow
);

  assign diff   = a ^ b ^ c;
  assign borrow = (~a & (b | c)) | (b & c);

endmodule

// File: rtl/serial_subtractor_ctrl.sv
// Bit-serial a - b - bin through one shared full_subtractor, LSB first; result valid W cycles
// after accept. Accepts only in IDLE; DONE holds outputs until out_ready, no queuing.
module serial_subtractor_ctrl
  import serial_subtractor_ctrl_pkg::*;
#(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         bin,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] diff,
  output logic         bout,
  output logic         ovf,
  output logic         busy
);

  localparam int CW = (W > 1) ? $clog2(W) : 1;
  localparam logic [CW-1:0] LAST = CW'(W - 1);

  logic [1:0]    r_state;
  logic [CW-1:0] r_cnt;
  logic [W-1:0]  r_a_sh;
  logic [W-1:0]  r_b_sh;
  logic [W-1:0]  r_diff_sh;
  logic          r_brw;
  logic          r_a_msb;
  logic          r_b_msb;
  logic          r_bout;
  logic          r_ovf;
  logic          r_in_ready;
  logic          r_out_valid;
  logic          r_busy;

  logic          w_cell_diff;
  logic          w_cell_borrow;
  logic          w_accept;
  logic          w_last;
  logic          w_release;

  full_subtractor u_cell (
    .a      (r_a_sh[0]),
    .b      (r_b_sh[0]),
    .c      (r_brw),
    .diff   (w_cell_diff),
    .borrow (w_cell_borrow)
  );

  assign w_accept  = (r_state == S_IDLE) && in_valid;
  assign w_last    = (r_state == S_RUN) && (r_cnt == LAST);
  assign w_release = (r_state == S_DONE) && out_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_cnt       <= '0;
      r_a_sh      <= '0;
      r_b_sh      <= '0;
      r_diff_sh   <= '0;
      r_brw       <= 1'b0;
      r_a_msb     <= 1'b0;
      r_b_msb     <= 1'b0;
      r_bout      <= 1'b0;
      r_ovf       <= 1'b0;
      r_in_ready  <= 1'b1;
      r_out_valid <= 1'b0;
      r_busy      <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_a_sh     <= a;
            r_b_sh     <= b;
            r_brw      <= bin;
            r_cnt      <= '0;
            r_a_msb    <= a[W-1];
            r_b_msb    <= b[W-1];
            r_state    <= S_RUN;
            r_in_ready <= 1'b0;
            r_busy     <= 1'b1;
          end
        end
        S_RUN: begin
          r_brw     <= w_cell_borrow;
          r_diff_sh <= {w_cell_diff, r_diff_sh[W-1:1]};
          r_a_sh    <= {1'b0, r_a_sh[W-1:1]};
          r_b_sh    <= {1'b0, r_b_sh[W-1:1]};
          // Counter holds at LAST rather than wrapping; it is reloaded on the next accept.
          if (w_last) begin
            r_state     <= S_DONE;
            r_bout      <= w_cell_borrow;
            r_ovf       <= sub_ovf(r_a_msb, r_b_msb, w_cell_diff);
            r_out_valid <= 1'b1;
          end else begin
            r_cnt <= r_cnt + CW'(1);
          end
        end
        S_DONE: begin
          if (w_release) begin
            r_state     <= S_IDLE;
            r_out_valid <= 1'b0;
            r_in_ready  <= 1'b1;
            r_busy      <= 1'b0;
          end
        end
        default: begin
          r_state     <= S_IDLE;
          r_out_valid <= 1'b0;
          r_in_ready  <= 1'b1;
          r_busy      <= 1'b0;
        end
      endcase
    end
  end

  assign in_ready  = r_in_ready;
  assign out_valid = r_out_valid;
  assign diff      = r_diff_sh;
  assign bout      = r_bout;
  assign ovf       = r_ovf;
  assign busy      = r_busy;

endmodule

// File: tb/tb_serial_subtractor_ctrl.sv
// Directed bench for serial_subtractor_ctrl at W=8 and W=2 with a queued a - b - bin model.
module tb_serial_subtractor_ctrl;
  import serial_subtractor_ctrl_pkg::*;

  typedef struct packed {
    logic [7:0] d;
    logic       bo;
    logic       of;
  } exp_t;

  logic       clk;
  logic       rst_n;

  logic       iv8, ir8, ov8, or8, bin8, bo8, of8, busy8;
  logic [7:0] a8, b8, d8;
  logic       iv2, ir2, ov2, or2, bin2, bo2, of2, busy2;
  logic [1:0] a2, b2, d2;

  int   nvec  = 0;
  int   nfail = 0;
  exp_t sb[$];

  serial_subtractor_ctrl #(.W(8)) dut8 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv8), .in_ready(ir8), .a(a8), .b(b8), .bin(bin8),
    .out_valid(ov8), .out_ready(or8), .diff(d8), .bout(bo8), .ovf(of8), .busy(busy8)
  );

  serial_subtractor_ctrl #(.W(2)) dut2 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv2), .in_ready(ir2), .a(a2), .b(b2), .bin(bin2),
    .out_valid(ov2), .out_ready(or2), .diff(d2), .bout(bo2), .ovf(of2), .busy(busy2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nvec++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic exp_t model(input int w, input logic [7:0] a, input logic [7:0] b, input logic bin);
    exp_t       e;
    logic [8:0] f8;
    logic [2:0] f2;
    if (w == 8) begin
      f8   = {1'b0, a} - {1'b0, b} - {8'b0, bin};
      e.d  = f8[7:0];
      e.bo = f8[8];
      e.of = (a[7] != b[7]) && (f8[7] != a[7]);
    end else begin
      f2   = {1'b0, a[1:0]} - {1'b0, b[1:0]} - {2'b0, bin};
      e.d  = {6'b0, f2[1:0]};
      e.bo = f2[2];
      e.of = (a[1] != b[1]) && (f2[1] != a[1]);
    end
    return e;
  endfunction

  function automatic exp_t obs(input int w);
    if (w == 8) return {d8, bo8, of8};
    return {6'b0, d2, bo2, of2};
  endfunction

  function automatic logic cur_ov(input int w);
    return (w == 8) ? ov8 : ov2;
  endfunction

  function automatic logic cur_ir(input int w);
    return (w == 8) ? ir8 : ir2;
  endfunction

  function automatic logic [1:0] cur_state(input int w);
    return (w == 8) ? dut8.r_state : dut2.r_state;
  endfunction

  task automatic set_in(input int w, input logic v, input logic [7:0] a, input logic [7:0] b, input logic bin);
    if (w == 8) begin
      iv8 = v; a8 = a; b8 = b; bin8 = bin;
    end else begin
      iv2 = v; a2 = a[1:0]; b2 = b[1:0]; bin2 = bin;
    end
  endtask

  task automatic set_or(input int w, input logic v);
    if (w == 8) or8 = v;
    else        or2 = v;
  endtask

  // Present one operand set, push its expected result, and confirm it was taken.
  task automatic drive_accept(input int w, input logic [7:0] a, input logic [7:0] b, input logic bin);
    @(negedge clk);
    set_in(w, 1'b1, a, b, bin);
    sb.push_back(model(w, a, b, bin));
    @(posedge clk);
    #1;
    set_in(w, 1'b0, 8'h00, 8'h00, 1'b0);
    chk("in_ready_after_accept", cur_ir(w), 0);
    chk("busy_after_accept", (w == 8) ? busy8 : busy2, 1);
  endtask

  // Wait for the result, check latency and value, optionally stall, then release.
  task automatic collect(input int w, input int hold);
    exp_t e;
    exp_t got;
    int   lat = 0;
    do begin
      @(posedge clk);
      #1;
      lat++;
    end while (!cur_ov(w) && lat < 40);
    chk("latency", lat, w);
    e   = sb.pop_front();
    got = obs(w);
    chk("diff", got.d, e.d);
    chk("bout", got.bo, e.bo);
    chk("ovf", got.of, e.of);
    for (int i = 0; i < hold; i++) begin
      if (i == 2) set_in(w, 1'b1, 8'hFF, 8'h00, 1'b0);
      @(posedge clk);
      #1;
      set_in(w, 1'b0, 8'h00, 8'h00, 1'b0);
      chk("hold_outputs", obs(w), e);
      chk("hold_out_valid", cur_ov(w), 1);
      chk("hold_in_ready", cur_ir(w), 0);
    end
    set_or(w, 1'b1);
    @(posedge clk);
    #1;
    set_or(w, 1'b0);
    chk("out_valid_drop", cur_ov(w), 0);
    chk("in_ready_back", cur_ir(w), 1);
    chk("state_idle", cur_state(w), S_IDLE);
  endtask

  task automatic do_op(input int w, input logic [7:0] a, input logic [7:0] b, input logic bin);
    drive_accept(w, a, b, bin);
    collect(w, 0);
  endtask

  initial begin
    rst_n = 1'b0;
    set_in(8, 1'b0, 8'h00, 8'h00, 1'b0);
    set_in(2, 1'b0, 8'h00, 8'h00, 1'b0);
    or8 = 1'b0;
    or2 = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_out_valid", ov8, 0);
    chk("rst_in_ready", ir8, 1);
    chk("rst_outputs", {d8, bo8, of8}, 0);
    chk("rst_busy", busy8, 0);
    chk("rst_w2_out_valid", ov2, 0);
    chk("rst_w2_in_ready", ir2, 1);
    @(negedge clk);
    rst_n = 1'b1;

    do_op(8, 8'h05, 8'h03, 1'b0);
    do_op(8, 8'h03, 8'h05, 1'b0);
    do_op(8, 8'h00, 8'h00, 1'b1);
    do_op(8, 8'h80, 8'h01, 1'b0);
    do_op(8, 8'h7F, 8'hFF, 1'b0);

    // Stall in DONE with a stray in_valid pulse, then confirm no extra result appears.
    drive_accept(8, 8'h3C, 8'h1A, 1'b0);
    collect(8, 5);
    repeat (3) @(posedge clk);
    #1;
    chk("no_queued_result", ov8, 0);

    // Reset mid-RUN at cnt=3; the partial result is discarded.
    drive_accept(8, 8'hC3, 8'h11, 1'b1);
    repeat (3) @(posedge clk);
    #1;
    chk("cnt_before_reset", dut8.r_cnt, 3);
    rst_n = 1'b0;
    #1;
    void'(sb.pop_front());
    chk("midrun_rst_out_valid", ov8, 0);
    chk("midrun_rst_in_ready", ir8, 1);
    chk("midrun_rst_outputs", {d8, bo8, of8}, 0);
    chk("midrun_rst_busy", busy8, 0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("no_pulse_after_reset", ov8, 0);
    do_op(8, 8'hA5, 8'h5A, 1'b1);

    for (int ia = 0; ia < 4; ia++) begin
      for (int ib = 0; ib < 4; ib++) begin
        for (int ic = 0; ic < 2; ic++) begin
          do_op(2, 8'(ia), 8'(ib), 1'(ic));
        end
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
    $finish;
  end

endmodule
